// File: rtl/mouse_cursor_tracker_if.sv
// Bus bundle between the PS/2 packet source, the VGA timing stage and the cursor tracker.
// The tracker is the slave; the packet/pixel source side is the master.
interface mouse_cursor_tracker_if;
  logic        PacketValid;
  logic [23:0] PacketData;
  logic        PixelTick;
  logic        VgaOn;
  logic [9:0]  PixelX;
  logic [9:0]  PixelY;
  logic [11:0] RGB;
  logic [9:0]  CursorX;
  logic [9:0]  CursorY;
  logic [2:0]  Buttons;
  logic        PacketErr;
  logic        PacketDrop;

  modport master (
    output PacketValid, PacketData, PixelTick, VgaOn, PixelX, PixelY,
    input  RGB, CursorX, CursorY, Buttons, PacketErr, PacketDrop
  );

  modport slave (
    input  PacketValid, PacketData, PixelTick, VgaOn, PixelX, PixelY,
    output RGB, CursorX, CursorY, Buttons, PacketErr, PacketDrop
  );
endinterface

// File: rtl/mouse_cursor_tracker.sv
// PS/2 packet -> clamped absolute cursor position, with a vblank-swapped display copy and RGB overlay.
// Optional macro CURSOR_CROSSHAIR_EN adds a grey crosshair through the cursor origin.
module mouse_cursor_tracker #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int INIT_X      = 320,
  parameter int INIT_Y      = 240,
  parameter int CURSOR_SIZE = 8
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  mouse_cursor_tracker_if.slave bus
);
  // state   | meaning
  // S_IDLE  | waiting for a packet; bad sync bit rejected here
  // S_ADD   | 11-bit signed sums formed from latched deltas
  // S_CLAMP | sums clamped and committed with buttons
  typedef enum logic [1:0] {S_IDLE, S_ADD, S_CLAMP} state_t;

  localparam logic signed [10:0] LP_XMAX = 11'(H_RES - 1);
  localparam logic signed [10:0] LP_YMAX = 11'(V_RES - 1);

  state_t             r_state, w_next;
  logic signed [10:0] r_dx, r_dy, r_sum_x, r_sum_y;
  logic signed [10:0] w_in_dx, w_in_dy;
  logic [2:0]         r_btn_new, r_btn, r_disp_btn;
  logic [9:0]         r_cur_x, r_cur_y, r_disp_x, r_disp_y;
  logic [9:0]         w_clamp_x, w_clamp_y;
  logic               r_err, r_drop;
  logic [11:0]        r_rgb, w_pix, w_colour;
  logic               w_latch, w_err, w_drop, w_add, w_commit, w_vblank;
  logic [10:0]        w_px, w_py, w_bx, w_by;
  logic               w_in_box;

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_latch  = 1'b0;
    w_err    = 1'b0;
    w_drop   = 1'b0;
    w_add    = 1'b0;
    w_commit = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.PacketValid) begin
          if (bus.PacketData[3]) begin
            w_latch = 1'b1;
            w_next  = S_ADD;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      S_ADD: begin
        w_add  = 1'b1;
        w_drop = bus.PacketValid;
        w_next = S_CLAMP;
      end
      S_CLAMP: begin
        w_commit = 1'b1;
        w_drop   = bus.PacketValid;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Overflowed axes contribute nothing; buttons still update.
  assign w_in_dx = bus.PacketData[6] ? 11'sd0 : {{3{bus.PacketData[4]}}, bus.PacketData[15:8]};
  assign w_in_dy = bus.PacketData[7] ? 11'sd0 : {{3{bus.PacketData[5]}}, bus.PacketData[23:16]};

  always_comb begin
    if (r_sum_x < 11'sd0)        w_clamp_x = '0;
    else if (r_sum_x > LP_XMAX)  w_clamp_x = LP_XMAX[9:0];
    else                         w_clamp_x = r_sum_x[9:0];
    if (r_sum_y < 11'sd0)        w_clamp_y = '0;
    else if (r_sum_y > LP_YMAX)  w_clamp_y = LP_YMAX[9:0];
    else                         w_clamp_y = r_sum_y[9:0];
  end

  assign w_vblank = bus.PixelTick && (bus.PixelX == 10'd0) && (bus.PixelY == 10'(V_RES));

  // Widened compares so a box near the right/bottom edge clips instead of wrapping.
  assign w_px     = {1'b0, bus.PixelX};
  assign w_py     = {1'b0, bus.PixelY};
  assign w_bx     = {1'b0, r_disp_x};
  assign w_by     = {1'b0, r_disp_y};
  assign w_in_box = (w_px >= w_bx) && (w_px < w_bx + 11'(CURSOR_SIZE)) &&
                    (w_py >= w_by) && (w_py < w_by + 11'(CURSOR_SIZE));
  assign w_colour = (r_disp_btn == 3'b000) ? 12'hFFF :
                    {{4{r_disp_btn[0]}}, {4{r_disp_btn[1]}}, {4{r_disp_btn[2]}}};

  always_comb begin
    w_pix = 12'h000;
    if (bus.VgaOn) begin
      if (w_in_box) w_pix = w_colour;
`ifdef CURSOR_CROSSHAIR_EN
      else if ((bus.PixelX == r_disp_x) || (bus.PixelY == r_disp_y)) w_pix = 12'h444;
`endif
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_dx       <= '0;
      r_dy       <= '0;
      r_btn_new  <= '0;
      r_sum_x    <= '0;
      r_sum_y    <= '0;
      r_cur_x    <= 10'(INIT_X);
      r_cur_y    <= 10'(INIT_Y);
      r_btn      <= '0;
      r_disp_x   <= 10'(INIT_X);
      r_disp_y   <= 10'(INIT_Y);
      r_disp_btn <= '0;
      r_err      <= 1'b0;
      r_drop     <= 1'b0;
      r_rgb      <= '0;
    end else begin
      r_err  <= w_err;
      r_drop <= w_drop;
      if (w_latch) begin
        r_dx      <= w_in_dx;
        r_dy      <= w_in_dy;
        r_btn_new <= bus.PacketData[2:0];
      end
      if (w_add) begin
        r_sum_x <= $signed({1'b0, r_cur_x}) + r_dx;
        r_sum_y <= $signed({1'b0, r_cur_y}) - r_dy;
      end
      if (w_commit) begin
        r_cur_x <= w_clamp_x;
        r_cur_y <= w_clamp_y;
        r_btn   <= r_btn_new;
      end
      // Nonblocking reads here give the pre-commit position when a commit coincides.
      if (w_vblank) begin
        r_disp_x   <= r_cur_x;
        r_disp_y   <= r_cur_y;
        r_disp_btn <= r_btn;
      end
      if (bus.PixelTick) r_rgb <= w_pix;
    end
  end

  assign bus.RGB        = r_rgb;
  assign bus.CursorX    = r_cur_x;
  assign bus.CursorY    = r_cur_y;
  assign bus.Buttons    = r_btn;
  assign bus.PacketErr  = r_err;
  assign bus.PacketDrop = r_drop;
endmodule

// File: tb/tb_mouse_cursor_tracker.sv
// Self-checking bench for mouse_cursor_tracker: randomized packets and pixels against a behavioural model.
module tb_mouse_cursor_tracker;
  logic i_Clk = 1'b0;
  logic i_Reset = 1'b1;
  always #5 i_Clk = ~i_Clk;

  mouse_cursor_tracker_if bus();
  mouse_cursor_tracker dut (.i_Clk(i_Clk), .i_Reset(i_Reset), .bus(bus));

  int checks = 0;
  int errors = 0;
  // Model state: working position/buttons and the displayed copy.
  int m_x, m_y, m_btn, m_dx, m_dy, m_dbtn;

  task automatic step();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic model_reset();
    m_x = 320; m_y = 240; m_btn = 0;
    m_dx = 320; m_dy = 240; m_dbtn = 0;
  endtask

  function automatic int clampi(int v, int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int delta(bit sgn, logic [7:0] mag, bit ovf);
    if (ovf) return 0;
    return sgn ? int'(mag) - 256 : int'(mag);
  endfunction

  task automatic model_apply(logic [23:0] p);
    int dx, dy;
    if (p[3] == 1'b0) return;
    dx = delta(p[4], p[15:8], p[6]);
    dy = delta(p[5], p[23:16], p[7]);
    m_x = clampi(m_x + dx, 639);
    m_y = clampi(m_y - dy, 479);
    m_btn = int'(p[2:0]);
  endtask

  function automatic logic [11:0] colour(int btn);
    logic [11:0] c;
    if (btn == 0) return 12'hFFF;
    c = 12'h000;
    if (btn & 1) c = c | 12'hF00;
    if (btn & 2) c = c | 12'h0F0;
    if (btn & 4) c = c | 12'h00F;
    return c;
  endfunction

  function automatic logic [11:0] exp_rgb(int x, int y, bit vga);
    if (!vga) return 12'h000;
    if (x >= m_dx && x < m_dx + 8 && y >= m_dy && y < m_dy + 8) return colour(m_dbtn);
`ifdef CURSOR_CROSSHAIR_EN
    if (x == m_dx || y == m_dy) return 12'h444;
`endif
    return 12'h000;
  endfunction

  function automatic logic [23:0] mk(int btn, int dx, int dy);
    logic [7:0] f;
    f = 8'h08 | 8'(btn & 7);
    if (dx < 0) f[4] = 1'b1;
    if (dy < 0) f[5] = 1'b1;
    return {8'(dy & 255), 8'(dx & 255), f};
  endfunction

  task automatic check_pos(string tag);
    checks++;
    if (bus.CursorX !== 10'(m_x)) begin
      errors++; $display("FAIL %s CursorX: got %0d expected %0d", tag, bus.CursorX, m_x);
    end
    checks++;
    if (bus.CursorY !== 10'(m_y)) begin
      errors++; $display("FAIL %s CursorY: got %0d expected %0d", tag, bus.CursorY, m_y);
    end
    checks++;
    if (bus.Buttons !== 3'(m_btn)) begin
      errors++; $display("FAIL %s Buttons: got %0h expected %0h", tag, bus.Buttons, m_btn);
    end
  endtask

  // One packet at edge N; pulses checked after N and N+1, position after N+1 (old) and N+2 (new).
  task automatic send_pkt(logic [23:0] p, string tag);
    bus.PacketValid = 1'b1;
    bus.PacketData  = p;
    step();
    bus.PacketValid = 1'b0;
    checks++;
    if (bus.PacketErr !== ~p[3]) begin
      errors++; $display("FAIL %s err pulse: got %0b expected %0b", tag, bus.PacketErr, ~p[3]);
    end
    checks++;
    if (bus.PacketDrop !== 1'b0) begin
      errors++; $display("FAIL %s drop: got %0b expected 0", tag, bus.PacketDrop);
    end
    step();
    checks++;
    if (bus.PacketErr !== 1'b0) begin
      errors++; $display("FAIL %s err width: got %0b expected 0", tag, bus.PacketErr);
    end
    check_pos({tag, " early"});
    step();
    model_apply(p);
    check_pos(tag);
  endtask

  task automatic pix(int x, int y, bit vga, string tag);
    logic [11:0] e;
    bus.PixelTick = 1'b1;
    bus.PixelX    = 10'(x);
    bus.PixelY    = 10'(y);
    bus.VgaOn     = vga;
    step();
    bus.PixelTick = 1'b0;
    e = exp_rgb(x, y, vga);
    checks++;
    if (bus.RGB !== e) begin
      errors++; $display("FAIL %s RGB(%0d,%0d): got %03h expected %03h", tag, x, y, bus.RGB, e);
    end
  endtask

  task automatic vblank();
    m_dx = m_x; m_dy = m_y; m_dbtn = m_btn;
    pix(0, 480, 1'b0, "vblank");
  endtask

  task automatic scan_box(int cx, int cy, string tag);
    for (int y = cy - 3; y < cy + 11; y++)
      for (int x = cx - 3; x < cx + 11; x++)
        pix(clampi(x, 1023), clampi(y, 1023), 1'b1, tag);
  endtask

  task automatic move_to(int tx, int ty);
    int ddx, ddy;
    for (int k = 0; k < 10; k++) begin
      if (m_x == tx && m_y == ty) break;
      ddx = tx - m_x;
      ddy = m_y - ty;
      if (ddx > 200) ddx = 200;
      if (ddx < -200) ddx = -200;
      if (ddy > 200) ddy = 200;
      if (ddy < -200) ddy = -200;
      send_pkt(mk(m_btn, ddx, ddy), "move_to");
    end
  endtask

  task automatic test_reset();
    logic [11:0] held;
    bus.PacketValid = 0; bus.PacketData = 0; bus.PixelTick = 0;
    bus.VgaOn = 0; bus.PixelX = 0; bus.PixelY = 0;
    i_Reset = 1'b1;
    step(); step();
    i_Reset = 1'b0;
    model_reset();
    step();
    check_pos("reset");
    checks++;
    if (bus.RGB !== 12'h000 || bus.PacketErr !== 1'b0 || bus.PacketDrop !== 1'b0) begin
      errors++; $display("FAIL reset outputs: got rgb=%03h err=%0b drop=%0b expected 0", bus.RGB, bus.PacketErr, bus.PacketDrop);
    end
    scan_box(320, 240, "reset_box");
    pix(323, 243, 1'b0, "reset_blank");
    pix(327, 247, 1'b1, "reset_corner");
    held = bus.RGB;
    bus.PixelX = 10'd0;
    step();
    checks++;
    if (bus.RGB !== held || held !== 12'hFFF) begin
      errors++; $display("FAIL rgb_hold: got %03h expected FFF", bus.RGB);
    end
    for (int i = 0; i < 20; i++) pix($urandom_range(0, 639), $urandom_range(0, 479), 1'b1, "reset_rand");
  endtask

  task automatic test_move();
    send_pkt(24'h03_05_08, "move");
    checks++;
    if (bus.CursorX !== 10'd325 || bus.CursorY !== 10'd237) begin
      errors++; $display("FAIL move abs: got %0d,%0d expected 325,237", bus.CursorX, bus.CursorY);
    end
  endtask

  task automatic test_clamp();
    move_to(5, 240);
    send_pkt(24'h00_F6_18, "clamp_x0");
    checks++;
    if (bus.CursorX !== 10'd0) begin
      errors++; $display("FAIL clamp_x0 abs: got %0d expected 0", bus.CursorX);
    end
    move_to(0, 470);
    send_pkt(24'hF6_00_28, "clamp_ymax");
    checks++;
    if (bus.CursorY !== 10'd479) begin
      errors++; $display("FAIL clamp_ymax abs: got %0d expected 479", bus.CursorY);
    end
    move_to(635, 5);
    send_pkt(mk(0, 20, 20), "clamp_xmax_y0");
    send_pkt(24'h80_50_4B, "overflow");
  endtask

  task automatic test_err_drop();
    move_to(320, 240);
    send_pkt(24'h10_10_00, "err");
    bus.PacketValid = 1'b1; bus.PacketData = mk(2, 7, 3);
    step();
    bus.PacketData = mk(4, -50, -50);
    step();
    bus.PacketValid = 1'b0;
    checks++;
    if (bus.PacketDrop !== 1'b1) begin
      errors++; $display("FAIL drop_add: got %0b expected 1", bus.PacketDrop);
    end
    step();
    model_apply(mk(2, 7, 3));
    check_pos("drop_add");
    checks++;
    if (bus.PacketDrop !== 1'b0) begin
      errors++; $display("FAIL drop width: got %0b expected 0", bus.PacketDrop);
    end
    // Second packet lands in CLAMP, then a third right after is accepted.
    bus.PacketValid = 1'b1; bus.PacketData = mk(0, -3, 4);
    step();
    bus.PacketValid = 1'b0;
    step();
    bus.PacketValid = 1'b1; bus.PacketData = mk(1, 90, 90);
    step();
    model_apply(mk(0, -3, 4));
    checks++;
    if (bus.PacketDrop !== 1'b1) begin
      errors++; $display("FAIL drop_clamp: got %0b expected 1", bus.PacketDrop);
    end
    check_pos("drop_clamp");
    bus.PacketValid = 1'b1; bus.PacketData = mk(4, 11, -12);
    step();
    bus.PacketValid = 1'b0;
    checks++;
    if (bus.PacketDrop !== 1'b0 || bus.PacketErr !== 1'b0) begin
      errors++; $display("FAIL back_to_back pulse: got drop=%0b err=%0b expected 0", bus.PacketDrop, bus.PacketErr);
    end
    step(); step();
    model_apply(mk(4, 11, -12));
    check_pos("back_to_back");
  endtask

  task automatic test_tear();
    send_pkt(mk(0, 320 - m_x, m_y - 240), "tear_home");
    vblank();
    for (int x = 0; x < 640; x += 37) pix(x, 100, 1'b1, "tear_line100");
    send_pkt(mk(1, 20, -20), "tear_move");
    scan_box(320, 240, "tear_old");
    vblank();
    scan_box(340, 260, "tear_new");
    checks++;
    if (m_dbtn != 1 || exp_rgb(342, 262, 1'b1) !== 12'hF00) begin
      errors++; $display("FAIL tear colour model: got %03h expected F00", exp_rgb(342, 262, 1'b1));
    end
  endtask

  task automatic test_vblank_race();
    logic [23:0] p;
    p = mk(2, -30, 30);
    bus.PacketValid = 1'b1; bus.PacketData = p;
    step();
    bus.PacketValid = 1'b0;
    step();
    m_dx = m_x; m_dy = m_y; m_dbtn = m_btn;
    model_apply(p);
    pix(0, 480, 1'b0, "race_vblank");
    check_pos("race_commit");
    scan_box(m_dx, m_dy, "race_old");
    vblank();
    scan_box(m_dx, m_dy, "race_new");
  endtask

  task automatic test_random();
    logic [23:0] p;
    for (int i = 0; i < 40; i++) begin
      p = 24'($urandom);
      if ($urandom_range(0, 7) != 0) p[3] = 1'b1;
      send_pkt(p, "rand_pkt");
      vblank();
      for (int j = 0; j < 8; j++)
        pix(clampi(m_dx + int'($urandom_range(0, 11)) - 2, 1023),
            clampi(m_dy + int'($urandom_range(0, 11)) - 2, 1023),
            1'($urandom_range(0, 5) != 0), "rand_near");
      pix($urandom_range(0, 639), $urandom_range(0, 479), 1'b1, "rand_any");
    end
  endtask

`ifdef CURSOR_CROSSHAIR_EN
  task automatic test_crosshair();
    move_to(320, 240);
    send_pkt(mk(0, 0, 0), "xhair_btn");
    vblank();
    pix(320, 10, 1'b1, "xhair_col");
    checks++;
    if (bus.RGB !== 12'h444) begin
      errors++; $display("FAIL xhair abs: got %03h expected 444", bus.RGB);
    end
    pix(321, 10, 1'b1, "xhair_off");
    pix(320, 240, 1'b1, "xhair_box");
    pix(10, 240, 1'b1, "xhair_row");
  endtask
`endif

  task automatic test_reset_mid();
    bus.PacketValid = 1'b1; bus.PacketData = mk(3, 50, 50);
    step();
    bus.PacketValid = 1'b0;
    #2 i_Reset = 1'b1;
    #1;
    model_reset();
    check_pos("reset_mid_async");
    step();
    i_Reset = 1'b0;
    step(); step(); step();
    check_pos("reset_mid_lost");
  endtask

  initial begin
    test_reset();
    test_move();
    test_clamp();
    test_err_drop();
    test_tear();
    test_vblank_race();
    test_random();
`ifdef CURSOR_CROSSHAIR_EN
    test_crosshair();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mouse_cursor_tracker.md
# mouse_cursor_tracker

Converts decoded PS/2 mouse packets into an absolute, screen-clamped cursor position and renders a cursor overlay as 12-bit RGB. It sits between the PS/2 mouse controller, which supplies the 3-byte packets, and the VGA output stage, which supplies the pixel coordinates and consumes the RGB. The display copy of the position is double-buffered and swapped only at the start of vertical blank, so the cursor never tears mid-frame.

## Interface
Parameters:
- H_RES, 640, horizontal visible pixels; X clamp is 0..H_RES-1
- V_RES, 480, vertical visible lines; Y clamp is 0..V_RES-1
- INIT_X, 320, X position after reset
- INIT_Y, 240, Y position after reset
- CURSOR_SIZE, 8, edge length in pixels of the square cursor box

Ports:
- Clk  input  1  system clock
- Reset  input  1  asynchronous, active-high reset
- PacketValid  input  1  one-cycle strobe; PacketData is valid
- PacketData  input  24  [7:0] flags byte, [15:8] X delta, [23:16] Y delta
- PixelTick  input  1  pixel enable from the VGA timing stage
- VgaOn  input  1  visible-area flag
- PixelX  input  10  current pixel column
- PixelY  input  10  current pixel line
- RGB  output  12  {R[11:8], G[7:4], B[3:0]}, registered
- CursorX  output  10  working X position
- CursorY  output  10  working Y position
- Buttons  output  3  {M, R, L} from the last accepted packet
- PacketErr  output  1  one-cycle pulse; packet rejected for bad sync bit
- PacketDrop  output  1  one-cycle pulse; packet arrived while the FSM was busy

## Operation
- Flags byte layout:
  - b0 L, b1 R, b2 M
  - b3 sync, must be 1
  - b4 X sign, b5 Y sign
  - b6 X overflow, b7 Y overflow
- Deltas are 9-bit two's complement: {sign, byte}.
- If an axis overflow bit is set, that axis delta is forced to 0. Buttons still update.
- PS/2 Y is positive upward. The screen update is CursorY = CursorY - dy.
- Sums are computed at 11-bit signed width, then clamped:
  - negative becomes 0
  - X greater than H_RES-1 becomes H_RES-1
  - Y greater than V_RES-1 becomes V_RES-1
- FSM states:
  - IDLE: on PacketValid with b3=1, latch the packet and go to ADD. With b3=0, pulse PacketErr and stay in IDLE; position and Buttons are unchanged.
  - ADD: form the 11-bit sums, then go to CLAMP.
  - CLAMP: commit CursorX, CursorY and Buttons, then return to IDLE.
- PacketValid seen in ADD or CLAMP: pulse PacketDrop and discard the packet. The packet in flight completes normally.
- Display registers DispX, DispY and DispBtn load from CursorX, CursorY and Buttons when PixelTick=1 && PixelX=0 && PixelY=V_RES.
  - If a CLAMP commit lands in the same cycle, the display registers take the pre-commit values.
- Rendering happens on each PixelTick:
  - If VgaOn=0, RGB becomes 0.
  - Else if DispX ≤ PixelX < DispX+CURSOR_SIZE and DispY ≤ PixelY < DispY+CURSOR_SIZE, RGB becomes the cursor colour.
  - Else RGB becomes 0.
  - Box comparisons use 11-bit arithmetic, so a cursor near the edge is clipped, not wrapped.
- Cursor colour is {L?F:0, R?F:0, M?F:0} nibbles. With no buttons pressed it is 12'hFFF.
- RGB holds its value between PixelTicks.

## Timing
- Reset values:
  - CursorX = DispX = INIT_X; CursorY = DispY = INIT_Y
  - Buttons = DispBtn = 0; RGB = 0
  - PacketErr = PacketDrop = 0; FSM in IDLE
- Latency: PacketValid at edge N gives CursorX, CursorY and Buttons updated after edge N+2.
- Throughput: one packet per 3 cycles. The PS/2 packet rate is far below this, so drops indicate an upstream fault.
- PacketErr and PacketDrop assert the cycle after the offending PacketValid, for exactly one cycle.
- RGB latency: one Clk after the PixelTick cycle whose PixelX/PixelY it represents.
- Reset asserted mid-operation forces all state to the reset values immediately. A packet in flight is lost.

## Configuration
- CURSOR_CROSSHAIR_EN defined: a pixel outside the box but with PixelX==DispX or PixelY==DispY, in the visible area, renders 12'h444. The box takes priority over the crosshair.
- CURSOR_CROSSHAIR_EN undefined: only the box is rendered; all other visible pixels are 0.

## Test plan
1. Reset released, then a frame of pixel stimulus: CursorX=320, CursorY=240, Buttons=0. RGB is 12'hFFF exactly for X 320..327, Y 240..247, and 0 elsewhere.
2. Packet 24'h03_05_08: after N+2, CursorX=325 and CursorY=237. No PacketErr or PacketDrop pulse.
3. From CursorX=5, packet 24'h00_F6_18 (dx=-10): CursorX=0. Then from CursorY=470, packet 24'h00_00_28 repeated with byte2=F6 (dy=-10): CursorY=479.
4. Packet 24'h10_10_00 (b3=0): PacketErr pulses once; position and Buttons are unchanged. A second PacketValid one cycle after a valid packet: PacketDrop pulses and only the first packet is applied.
5. Commit a move plus L-press mid-frame at PixelY=100: the remaining lines still show a white box at the old position. After the PixelY=480 latch, the next frame shows a 12'hF00 box at the new position.
6. With CURSOR_CROSSHAIR_EN: at DispX=320, pixel (320,10) gives 12'h444; pixel (321,10) gives 0; pixel (320,240) gives the box colour.
